stream_fifo: RTL

- Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
- It is the generic buffering stage that sits directly in front of a consuming component, decoupling producer and consumer rates.
- It absorbs bursts and exposes occupancy and almost-full status for upstream flow control.
- The payload width default matches the library-wide default data width of 8.

---
 rtl/stream_fifo.sv | 105 ++++++++++
 1 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO with valid/ready on both sides.
// The head entry is presented from a register (out_data), so every output
// is a flop and there is no combinational path from input to output.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready
// on that side. The producer holds in_data stable while in_valid is high
// and in_ready is low. The FIFO holds out_data/out_valid stable while
// out_valid is high and out_ready is low. in_ready depends only on
// internal state, never on out_ready.
module stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  almost_full_q, almost_full_d;
  logic                  push, pop;

  // Handshake decode and next-state computation for pointers, count and outputs.
  always_comb begin
    push          = in_valid && in_ready_q;
    pop           = out_valid_q && out_ready;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    out_data_d    = out_data_q;

    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The new head is the incoming word when it lands exactly at the next
    // read slot (FIFO empty after this edge's pop); otherwise it is in memory.
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) out_data_d = in_data;
      else                                out_data_d = mem_q[rd_ptr_d];
    end

    out_valid_d   = (count_d != '0);
    in_ready_d    = (count_d != DEPTH_C);
    almost_full_d = (count_d >= AF_C);
  end

  // State registers; asynchronous reset clears everything but the storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Storage write on an accepted push; contents are never reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign count       = count_q;
  assign almost_full = almost_full_q;

endmodule
